// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//
// Purpose: drives a bank of LEDs with one of four patterns, all derived from a
// single free-running counter:
//   mode 0 PRIORITY - counter taps, at most one LED lit, channel 0 wins
//   mode 1 CHASE    - one-hot pattern rotated left on every tick
//   mode 2 BINARY   - top counter bits shown directly
//   mode 3 PWM      - all LEDs follow (counter[7:0] < duty)
//
// Ports:
//   sys_clk   in   1         only clock
//   sys_rst   in   1         synchronous active-high reset
//   mode_sel  in   2         requested mode
//   mode_load in   1         one-cycle strobe capturing mode_sel and duty
//   duty      in   8         PWM duty (0 = off, 255 = on 255 of 256 cycles)
//   leds      out  NUM_LEDS  registered LED drive, active-high
//   tick      out  1         registered one-cycle pulse every 2^(TICK_BIT+1)
//
// Configuration macro: LED_PATTERN_PWM_EN
//   defined   - mode 3 produces the PWM pattern (duty is captured)
//   undefined - duty is ignored, no duty register or comparator, mode 3 = off
// -----------------------------------------------------------------------------
module led_pattern_gen #(
  parameter int NUM_LEDS  = 3,
  parameter int CNT_WIDTH = 24,
  parameter int TAP_BASE  = 8,
  parameter int TAP_STEP  = 4,
  parameter int TICK_BIT  = 20
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [1:0]          mode_sel,
  input  logic                mode_load,
  input  logic [7:0]          duty,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  typedef enum logic [1:0] {
    MODE_PRIORITY = 2'd0,
    MODE_CHASE    = 2'd1,
    MODE_BINARY   = 2'd2,
    MODE_PWM      = 2'd3
  } mode_t;

  localparam logic [NUM_LEDS-1:0] CHASE_INIT = NUM_LEDS'(1);

  logic [CNT_WIDTH-1:0] counter_q;
  mode_t                mode_q;
  logic [NUM_LEDS-1:0]  chase_q;
  logic [NUM_LEDS-1:0]  taps;
  logic [NUM_LEDS-1:0]  prio_leds;
  logic [NUM_LEDS-1:0]  chase_rot;
  logic [NUM_LEDS-1:0]  next_leds;
  logic                 prio_hit;

`ifdef LED_PATTERN_PWM_EN
  logic [7:0] duty_q;
  logic       pwm_on;

  assign pwm_on = (counter_q[7:0] < duty_q);
`else
  logic unused_duty;

  assign unused_duty = ^duty;
`endif

  // Each channel watches its own counter bit; higher channels use slower bits.
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_taps
    assign taps[g] = counter_q[TAP_BASE + g*TAP_STEP];
  end

  // Lowest-index active tap wins, so no more than one LED is ever lit.
  always_comb begin
    prio_leds = '0;
    prio_hit  = 1'b0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      if (!prio_hit && taps[k]) begin
        prio_leds[k] = 1'b1;
        prio_hit     = 1'b1;
      end
    end
  end

  // Rotate-left by one written per bit so a single-channel build still works.
  always_comb begin
    chase_rot = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      chase_rot[(k + 1) % NUM_LEDS] = chase_q[k];
    end
  end

  // Pattern selection uses the current mode and counter; the result is
  // registered, giving every mode the same one-cycle latency.
  always_comb begin
    next_leds = '0;
    case (mode_q)
      MODE_PRIORITY: next_leds = prio_leds;
      MODE_CHASE:    next_leds = chase_q;
      MODE_BINARY:   next_leds = counter_q[CNT_WIDTH-1 -: NUM_LEDS];
`ifdef LED_PATTERN_PWM_EN
      MODE_PWM:      next_leds = {NUM_LEDS{pwm_on}};
`else
      MODE_PWM:      next_leds = '0;
`endif
      default:       next_leds = '0;
    endcase
  end

  // Counter, mode registers, chase state and registered outputs. A CHASE load
  // restarts the chase and takes precedence over a tick in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      counter_q <= '0;
      mode_q    <= MODE_PRIORITY;
      chase_q   <= CHASE_INIT;
      leds      <= '0;
      tick      <= 1'b0;
`ifdef LED_PATTERN_PWM_EN
      duty_q    <= 8'd0;
`endif
    end else begin
      counter_q <= counter_q + 1'b1;
      tick      <= &counter_q[TICK_BIT:0];
      leds      <= next_leds;
      if (mode_load) begin
        mode_q <= mode_t'(mode_sel);
`ifdef LED_PATTERN_PWM_EN
        duty_q <= duty;
`endif
      end
      if (mode_load && (mode_sel == MODE_CHASE)) begin
        chase_q <= CHASE_INIT;
      end else if (tick && (mode_q == MODE_CHASE)) begin
        chase_q <= chase_rot;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Self-checking bench for led_pattern_gen with NUM_LEDS=3, CNT_WIDTH=12,
// TAP_BASE=2, TAP_STEP=3, TICK_BIT=7. A bench-side cycle counter tracks where
// the design counter should be; expected LED values are pushed to a queue when
// the stimulus point is reached and popped when the registered output appears.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int NUM_LEDS  = 3;
  localparam int CNT_WIDTH = 12;
  localparam int WAIT_MAX  = 4200;
  localparam int TICK_MAX  = 300;

`ifdef LED_PATTERN_PWM_EN
  localparam logic [2:0] PWM_HI  = 3'b111;
  localparam int         PWM_C64 = 64;
`else
  localparam logic [2:0] PWM_HI  = 3'b000;
  localparam int         PWM_C64 = 0;
`endif

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [7:0] duty;
    logic [11:0] cnt;
    logic [2:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] exp;
  } sb_t;

  logic                 sys_clk;
  logic                 sys_rst;
  logic [1:0]           mode_sel;
  logic                 mode_load;
  logic [7:0]           duty;
  logic [NUM_LEDS-1:0]  leds;
  logic                 tick;

  logic [CNT_WIDTH-1:0] cyc;
  int                   total;
  int                   bad;
  sb_t                  sb[$];
  vec_t                 vecs[15];

  led_pattern_gen #(
    .NUM_LEDS (3),
    .CNT_WIDTH(12),
    .TAP_BASE (2),
    .TAP_STEP (3),
    .TICK_BIT (7)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .mode_sel (mode_sel),
    .mode_load(mode_load),
    .duty     (duty),
    .leds     (leds),
    .tick     (tick)
  );

  // Free-running clock, 10 time units per cycle.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Bench copy of where the design counter should be in the current cycle.
  always @(posedge sys_clk) begin
    if (sys_rst) cyc <= '0;
    else         cyc <= cyc + 1'b1;
  end

  function automatic vec_t mkVec(string n, logic [1:0] m, logic [7:0] d,
                                 logic [11:0] c, logic [2:0] e);
    vec_t v;
    v.name = n;
    v.mode = m;
    v.duty = d;
    v.cnt  = c;
    v.exp  = e;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkScoreboard();
    sb_t item;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      item = sb.pop_front();
      checkOutput(item.name, 32'(leds), 32'(item.exp));
    end
  endtask

  task automatic waitCount(logic [11:0] target);
    int n = 0;
    while (cyc != target && n < WAIT_MAX) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= WAIT_MAX) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_count: got cyc=%0h expected %0h", cyc, target);
    end
  endtask

  task automatic waitTick(output logic [11:0] at);
    int n = 0;
    while (tick !== 1'b1 && n < TICK_MAX) begin
      @(negedge sys_clk);
      n++;
    end
    at = cyc;
    if (n >= TICK_MAX) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_tick: got no tick expected one within %0d", TICK_MAX);
    end
  endtask

  task automatic loadMode(logic [1:0] m, logic [7:0] d);
    mode_sel  = m;
    duty      = d;
    mode_load = 1'b1;
    @(negedge sys_clk);
    mode_load = 1'b0;
  endtask

  task automatic checkAt(string name, logic [11:0] c, logic [2:0] e);
    sb_t item;
    waitCount(c);
    item.name = name;
    item.exp  = e;
    sb.push_back(item);
    @(negedge sys_clk);
    checkScoreboard();
  endtask

  task automatic applyStimulus(vec_t v);
    loadMode(v.mode, v.duty);
    checkAt(v.name, v.cnt, v.exp);
  endtask

  task automatic countWindow(output int hi, output int mixed);
    hi    = 0;
    mixed = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge sys_clk);
      if (leds == 3'b111) hi++;
      else if (leds != 3'b000) mixed++;
    end
  endtask

  initial begin
    logic [11:0] t_now;
    logic [11:0] t_prev;
    logic [2:0]  chase_exp[6];
    int          hi;
    int          mixed;
    sb_t         item;

    total     = 0;
    bad       = 0;
    sys_rst   = 1'b1;
    mode_sel  = 2'd0;
    mode_load = 1'b0;
    duty      = 8'd0;

    vecs[0]  = mkVec("prio_004", 2'd0, 8'd0,   12'h004, 3'b001);
    vecs[1]  = mkVec("prio_020", 2'd0, 8'd0,   12'h020, 3'b010);
    vecs[2]  = mkVec("prio_024", 2'd0, 8'd0,   12'h024, 3'b001);
    vecs[3]  = mkVec("prio_100", 2'd0, 8'd0,   12'h100, 3'b100);
    vecs[4]  = mkVec("prio_120", 2'd0, 8'd0,   12'h120, 3'b010);
    vecs[5]  = mkVec("prio_124", 2'd0, 8'd0,   12'h124, 3'b001);
    vecs[6]  = mkVec("prio_000", 2'd0, 8'd0,   12'h000, 3'b000);
    vecs[7]  = mkVec("bin_3ff",  2'd2, 8'd0,   12'h3FF, 3'b001);
    vecs[8]  = mkVec("bin_a00",  2'd2, 8'd0,   12'hA00, 3'b101);
    vecs[9]  = mkVec("bin_e00",  2'd2, 8'd0,   12'hE00, 3'b111);
    vecs[10] = mkVec("bin_004",  2'd2, 8'd0,   12'h004, 3'b000);
    vecs[11] = mkVec("pwm_03f",  2'd3, 8'd64,  12'h03F, PWM_HI);
    vecs[12] = mkVec("pwm_040",  2'd3, 8'd64,  12'h040, 3'b000);
    vecs[13] = mkVec("pwm_0fe",  2'd3, 8'd255, 12'h0FE, PWM_HI);
    vecs[14] = mkVec("pwm_0ff",  2'd3, 8'd255, 12'h0FF, 3'b000);

    chase_exp[0] = 3'b010;
    chase_exp[1] = 3'b100;
    chase_exp[2] = 3'b001;
    chase_exp[3] = 3'b010;
    chase_exp[4] = 3'b100;
    chase_exp[5] = 3'b001;

    $display("[TB] start");

    // Reset held for three cycles: outputs stay low throughout.
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checkOutput("rst_outputs", {28'd0, tick, leds}, 32'd0);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("rst_counter_1", 32'(dut.counter_q), 32'd1);
    checkOutput("rst_leds_after", 32'(leds), 32'd0);

    // Table-driven pattern checks.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
    end

    // Tick timing around the 0xFF -> 0x100 boundary.
    waitCount(12'h0FF);
    checkOutput("tick_before", 32'(tick), 32'd0);
    @(negedge sys_clk);
    checkOutput("tick_on", 32'(tick), 32'd1);
    @(negedge sys_clk);
    checkOutput("tick_after", 32'(tick), 32'd0);

    // Chase: load, then follow six ticks; the sixth coincides with a reload.
    waitCount(12'h210);
    loadMode(2'd1, 8'd0);
    item.name = "chase_load";
    item.exp  = 3'b001;
    sb.push_back(item);
    @(negedge sys_clk);
    checkScoreboard();
    t_prev = '0;
    for (int i = 0; i < 6; i++) begin
      waitTick(t_now);
      if (i > 0) checkOutput("tick_period", 32'(t_now - t_prev), 32'd256);
      t_prev = t_now;
      if (i == 5) begin
        mode_sel  = 2'd1;
        mode_load = 1'b1;
        @(negedge sys_clk);
        mode_load = 1'b0;
        checkOutput("chase_sim_hold", 32'(leds), 32'b100);
        @(negedge sys_clk);
        checkOutput("chase_sim_load", 32'(leds), 32'(chase_exp[i]));
        @(negedge sys_clk);
        checkOutput("chase_sim_stay", 32'(leds), 32'b001);
      end else begin
        @(negedge sys_clk);
        @(negedge sys_clk);
        checkOutput("chase_step", 32'(leds), 32'(chase_exp[i]));
      end
    end

    // Back-to-back loads: the second (BINARY) must be the one that sticks.
    mode_sel  = 2'd1;
    mode_load = 1'b1;
    @(negedge sys_clk);
    mode_sel  = 2'd2;
    @(negedge sys_clk);
    mode_load = 1'b0;
    checkAt("last_load_wins", 12'hE00, 3'b111);

    // PWM duty counting over one full 256-cycle window.
    loadMode(2'd3, 8'd64);
    @(negedge sys_clk);
    countWindow(hi, mixed);
    checkOutput("pwm64_high", 32'(hi), 32'(PWM_C64));
    checkOutput("pwm64_mixed", 32'(mixed), 32'd0);
    loadMode(2'd3, 8'd0);
    @(negedge sys_clk);
    countWindow(hi, mixed);
    checkOutput("pwm0_high", 32'(hi), 32'd0);
    checkOutput("pwm0_mixed", 32'(mixed), 32'd0);

    // Reset in the middle of BINARY: pattern aborted, PRIORITY again.
    loadMode(2'd2, 8'd0);
    waitCount(12'hC00);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    checkOutput("midrst_outputs", {28'd0, tick, leds}, 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("midrst_counter", 32'(dut.counter_q), 32'd1);
    checkAt("midrst_prio", 12'h020, 3'b010);

    // Reset beats a simultaneous BINARY load.
    sys_rst   = 1'b1;
    mode_sel  = 2'd2;
    mode_load = 1'b1;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    mode_load = 1'b0;
    @(negedge sys_clk);
    checkOutput("rstload_counter", 32'(dut.counter_q), 32'd1);
    checkAt("rstload_prio", 12'h100, 3'b100);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
